// File: rtl/decode_issue.sv
// Decode/issue stage: 32x64 register file with write-back bypass feeding a one-entry ALU operand register.
// Optional build macro ILLEGAL_TRAP_EN adds a sticky 'illegal' output that halts intake on an unknown opcode.
module decode_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] a,
    output logic [63:0] b,
    output logic [1:0]  alu_op,
    output logic [1:0]  f3,
    output logic [1:0]  f7,
    output logic [4:0]  rd
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10
    } alu_op_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [63:0] regs_q [32];
    logic [63:0] regs_d [32];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_rd != 5'd0)) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the register file is reset explicitly because architectural state must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // A write landing this cycle is forwarded so back-to-back dependents see it without a stall.
    function automatic logic [63:0] src_val(
        input logic [4:0]  idx,
        input logic [63:0] rf_val,
        input logic        byp_en,
        input logic [4:0]  byp_idx,
        input logic [63:0] byp_data
    );
        logic [63:0] val;
        val = rf_val;
        if (idx == 5'd0) begin
            val = '0;
        end else if (byp_en && (byp_idx == idx)) begin
            val = byp_data;
        end
        return val;
    endfunction

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic        unused_funct3_msb;

    assign opcode  = instr[6:0];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign imm_i   = {{52{instr[31]}}, instr[31:20]};
    assign imm_s   = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign rs1_val = src_val(rs1, regs_q[rs1], wb_en, wb_rd, wb_data);
    assign rs2_val = src_val(rs2, regs_q[rs2], wb_en, wb_rd, wb_data);
    assign unused_funct3_msb = instr[14];

    logic        dec_legal;
    logic [63:0] dec_a;
    logic [63:0] dec_b;
    alu_op_e     dec_op;
    logic [1:0]  dec_f3;
    logic [1:0]  dec_f7;
    logic [4:0]  dec_rd;

    always_comb begin
        dec_legal = 1'b1;
        dec_a     = rs1_val;
        dec_b     = rs2_val;
        dec_op    = ALU_RTYPE;
        dec_f3    = 2'b00;
        dec_f7    = 2'b00;
        dec_rd    = 5'd0;
        case (opcode)
            OP_RTYPE: begin
                dec_op = ALU_RTYPE;
                dec_f3 = instr[13:12];
                dec_f7 = {1'b0, instr[30]};
                dec_rd = instr[11:7];
            end
            OP_LOAD: begin
                dec_op = ALU_ADD;
                dec_b  = imm_i;
                dec_rd = instr[11:7];
            end
            OP_STORE: begin
                dec_op = ALU_ADD;
                dec_b  = imm_s;
            end
            OP_BRANCH: begin
                dec_op = ALU_SUB;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One-entry output register and handshake
    // ------------------------------------------------------------------
    logic        out_valid_q, out_valid_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    alu_op_e     alu_op_q, alu_op_d;
    logic [1:0]  f3_q, f3_d;
    logic [1:0]  f7_q, f7_d;
    logic [4:0]  rd_q, rd_d;
    logic        accept;
    logic        consume;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign in_ready = (!out_valid_q || out_ready) && !illegal_q;
    assign illegal  = illegal_q;
    assign illegal_d = illegal_q || (accept && !dec_legal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;
`endif

    assign accept  = in_valid && in_ready;
    assign consume = out_valid_q && out_ready;

    // An accepted illegal opcode loads nothing and leaves the slot empty.
    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_op_d    = alu_op_q;
        f3_d        = f3_q;
        f7_d        = f7_q;
        rd_d        = rd_q;
        if (accept) begin
            out_valid_d = dec_legal;
            if (dec_legal) begin
                a_d      = dec_a;
                b_d      = dec_b;
                alu_op_d = dec_op;
                f3_d     = dec_f3;
                f7_d     = dec_f7;
                rd_d     = dec_rd;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            alu_op_q    <= ALU_ADD;
            f3_q        <= 2'b00;
            f7_q        <= 2'b00;
            rd_q        <= 5'd0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_op_q    <= alu_op_d;
            f3_q        <= f3_d;
            f7_q        <= f7_d;
            rd_q        <= rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign a         = a_q;
    assign b         = b_q;
    assign alu_op    = alu_op_q;
    assign f3        = f3_q;
    assign f7        = f7_q;
    assign rd        = rd_q;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: expected entries are queued on accept and popped by a monitor on consume.
// Covers ILLEGAL_TRAP_EN in both builds.
module tb_decode_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  alu_op;
    logic [1:0]  f3;
    logic [1:0]  f7;
    logic [4:0]  rd;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    decode_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .f3        (f3),
        .f7        (f7),
        .rd        (rd)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal   (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
        logic [1:0]  f3;
        logic [1:0]  f7;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] ea, input logic [63:0] eb, input logic [1:0] op,
                                input logic [1:0] ef3, input logic [1:0] ef7, input logic [4:0] erd);
        exp_t e;
        e.a  = ea;
        e.b  = eb;
        e.op = op;
        e.f3 = ef3;
        e.f7 = ef7;
        e.rd = erd;
        return e;
    endfunction

    // Monitor: every consumed entry must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got a=0x%0h rd=%0d with empty scoreboard", a, rd);
            end else begin
                mon_e = sb_q.pop_front();
                check("mon_a",      a,           mon_e.a);
                check("mon_b",      b,           mon_e.b);
                check("mon_alu_op", 64'(alu_op), 64'(mon_e.op));
                check("mon_f3",     64'(f3),     64'(mon_e.f3));
                check("mon_f7",     64'(f7),     64'(mon_e.f7));
                check("mon_rd",     64'(rd),     64'(mon_e.rd));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic wb_write(input logic [4:0] idx, input logic [63:0] data);
        wb_en   = 1'b1;
        wb_rd   = idx;
        wb_data = data;
        @(posedge clk);
        #1;
        wb_en   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] word, input logic push, input exp_t e);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        instr    = word;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: instr 0x%08h not accepted within 20 cycles", word);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            if (push) sb_q.push_back(e);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        wb_en     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_a",         a,              64'd0);
        check("rst_b",         b,              64'd0);
        check("rst_alu_op",    64'(alu_op),    64'd0);
        check("rst_rd",        64'(rd),        64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // add x3,x1,x2 with x1=32, x2=1
        wb_write(5'd1, 64'd32);
        wb_write(5'd2, 64'd1);
        issue(32'h002081B3, 1'b1, mk(64'd32, 64'd1, 2'b10, 2'b00, 2'b00, 5'd3));
        @(negedge clk);
        check("add_latency_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("consume_clears_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // ld x5,-8(x1) with x1 all ones
        wb_write(5'd1, ONES);
        issue(32'hFF80B283, 1'b1, mk(ONES, 64'hFFFF_FFFF_FFFF_FFF8, 2'b00, 2'b00, 2'b00, 5'd5));
        idle_cycle();

        // Back-pressure: sltu x7,x1,x2 held while sd x2,12(x1) waits
        out_ready = 1'b0;
        issue(32'h0020B3B3, 1'b1, mk(ONES, 64'd1, 2'b10, 2'b11, 2'b00, 5'd7));
        in_valid = 1'b1;
        instr    = 32'h0020B623;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready),  64'd0);
            check("stall_valid",    64'(out_valid), 64'd1);
            check("stall_a",        a,              ONES);
            check("stall_b",        b,              64'd1);
            check("stall_f3",       64'(f3),        64'd3);
            check("stall_rd",       64'(rd),        64'd7);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        sb_q.push_back(mk(ONES, 64'd12, 2'b00, 2'b00, 2'b00, 5'd0));
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("full_throughput_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // sub x4,x1,x2 in the same cycle as x2 <= 33 (bypass)
        wb_en   = 1'b1;
        wb_rd   = 5'd2;
        wb_data = 64'd33;
        issue(32'h40208233, 1'b1, mk(ONES, 64'd33, 2'b10, 2'b00, 2'b01, 5'd4));
        wb_en   = 1'b0;
        // bne x1,x2 with nonzero imm[4:1] and funct3=001: rd and f3 forced to 0
        issue(32'h00209463, 1'b1, mk(ONES, 64'd33, 2'b01, 2'b00, 2'b00, 5'd0));
        // sd x2,-4(x1)
        issue(32'hFE20BE23, 1'b1, mk(ONES, 64'hFFFF_FFFF_FFFF_FFFC, 2'b00, 2'b00, 2'b00, 5'd0));

        // x0 is hardwired: earlier write, and same-cycle write must not bypass
        wb_write(5'd0, 64'd5);
        issue(32'h00000333, 1'b1, mk(64'd0, 64'd0, 2'b10, 2'b00, 2'b00, 5'd6));
        wb_en   = 1'b1;
        wb_rd   = 5'd0;
        wb_data = 64'd7;
        issue(32'h00000333, 1'b1, mk(64'd0, 64'd0, 2'b10, 2'b00, 2'b00, 5'd6));
        wb_en   = 1'b0;
        idle_cycle();

        // Illegal opcode
        issue(32'h0000007F, 1'b0, mk(64'd0, 64'd0, 2'b00, 2'b00, 2'b00, 5'd0));
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("illegal_set",      64'(illegal),   64'd1);
            check("illegal_in_ready", 64'(in_ready),  64'd0);
            check("illegal_no_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("illegal_cleared_by_rst", 64'(illegal), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("illegal_in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
`else
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("illegal_no_valid", 64'(out_valid), 64'd0);
            check("illegal_in_ready", 64'(in_ready),  64'd1);
            @(posedge clk);
            #1;
        end
`endif

        // Reset asserted while an entry is held
        wb_write(5'd1, 64'd9);
        out_ready = 1'b0;
        issue(32'h002081B3, 1'b0, mk(64'd0, 64'd0, 2'b00, 2'b00, 2'b00, 5'd0));
        @(negedge clk);
        check("held_valid", 64'(out_valid), 64'd1);
        check("held_a",     a,              64'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid",  64'(out_valid), 64'd0);
        check("midrst_a",      a,              64'd0);
        check("midrst_rd",     64'(rd),        64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready),  64'd1);
        check("midrst_empty",    64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        // Register file was cleared by reset
        issue(32'h002081B3, 1'b1, mk(64'd0, 64'd0, 2'b10, 2'b00, 2'b00, 5'd3));
        idle_cycle();
        idle_cycle();

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
